// File: rtl/apb_cmd_arb.sv
// apb_cmd_arb: round-robin arbiter that funnels NREQ command requesters
// onto one APB master, one transaction in flight, with a WAIT timeout.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_cmd/req_vld/req_rdy   per-requester command {wr,addr,data} handshake
//   rsp_vld/rsp_data/rsp_err  per-requester completion strobe, read data, timeout
//   m_cmd/m_cmd_vld/m_cmd_rdy command channel to the APB master
//   m_transfer                keeps the APB master transferring
//   m_done/m_read_vld/m_read_data  APB completion and read data
//   grant, busy               current bus owner, non-idle flag
module apb_cmd_arb #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CMD_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  output logic [NREQ-1:0]           rsp_vld,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic [CMD_WIDTH-1:0]      m_cmd,
  output logic                      m_cmd_vld,
  output logic                      m_transfer,
  input  logic                      m_cmd_rdy,
  input  logic                      m_done,
  input  logic                      m_read_vld,
  input  logic [DATA_WIDTH-1:0]     m_read_data,
  output logic [NREQ-1:0]           grant,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [CMD_WIDTH-1:0]  cmd_buf_q, cmd_buf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NREQ-1:0]       grant_q, grant_d;
  logic [NREQ-1:0]       rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [NREQ-1:0]       req_rdy_c;

  logic found;
  int   win;
  int   idx;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cmd_buf_d  = cmd_buf_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    rsp_vld_d  = '0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    req_rdy_c  = '0;
    found      = 1'b0;
    win        = 0;
    idx        = 0;

    // First valid requester at or after rr_ptr, wrapping.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_rdy_c[win] = 1'b1;
          cmd_buf_d = req_cmd[win*CMD_WIDTH +: CMD_WIDTH];
          grant_d   = NREQ'(1) << win;
          rr_ptr_d  = PW'((win + 1) % NREQ);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_cmd_rdy) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion beats timeout when both land together.
        if (m_done) begin
          state_d   = IDLE;
          grant_d   = '0;
          rsp_vld_d = grant_q;
          if (!cmd_buf_q[CMD_WIDTH-1] && m_read_vld)
            rsp_data_d = m_read_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          rsp_vld_d = grant_q;
          rsp_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cmd_buf_q  <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cmd_buf_q  <= cmd_buf_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // req_rdy is combinational, so it is masked to stay quiet in reset.
  assign req_rdy    = rstn ? req_rdy_c : '0;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign m_cmd      = cmd_buf_q;
  assign m_cmd_vld  = (state_q == ISSUE);
  assign m_transfer = (state_q != IDLE);
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_apb_cmd_arb.sv
// tb_apb_cmd_arb: directed bench for apb_cmd_arb with a response scoreboard.
// Default parameters: NREQ=4, 8-bit data/addr, TIMEOUT=16.
module tb_apb_cmd_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CMW  = 17;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ*CMW-1:0]  req_cmd;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_rdy;
  logic [NREQ-1:0]      rsp_vld;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_err;
  logic [CMW-1:0]       m_cmd;
  logic                 m_cmd_vld;
  logic                 m_transfer;
  logic                 m_cmd_rdy;
  logic                 m_done;
  logic                 m_read_vld;
  logic [DW-1:0]        m_read_data;
  logic [NREQ-1:0]      grant;
  logic                 busy;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [DW-1:0]   data;
    logic            err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  apb_cmd_arb dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_cmd     (req_cmd),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .m_cmd       (m_cmd),
    .m_cmd_vld   (m_cmd_vld),
    .m_transfer  (m_transfer),
    .m_cmd_rdy   (m_cmd_rdy),
    .m_done      (m_done),
    .m_read_vld  (m_read_vld),
    .m_read_data (m_read_data),
    .grant       (grant),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NREQ-1:0] m, input logic [DW-1:0] d,
                      input logic e);
    exp_t x;
    x.mask = m;
    x.data = d;
    x.err  = e;
    q.push_back(x);
  endtask

  // Scoreboard: every rsp_vld pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (|rsp_vld) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_vld), 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_vld", 32'(rsp_vld), 32'(e.mask));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Accept requester r alone, then pass ISSUE; ends on first WAIT cycle.
  task automatic start_txn(input int r, input logic [CMW-1:0] cmd);
    req_cmd[r*CMW +: CMW] = cmd;
    req_vld = NREQ'(1) << r;
    #1;
    chk("req_rdy", 32'(req_rdy), 32'(NREQ'(1) << r));
    tick();
    req_vld = '0;
    chk("grant", 32'(grant), 32'(NREQ'(1) << r));
    chk("issue_vld", 32'(m_cmd_vld), 32'h1);
    chk("issue_cmd", 32'(m_cmd), 32'(cmd));
    chk("issue_rdy0", 32'(req_rdy), 32'h0);
    m_cmd_rdy = 1'b1;
    tick();
    m_cmd_rdy = 1'b0;
    chk("wait_vld", 32'(m_cmd_vld), 32'h0);
    chk("wait_xfer", 32'(m_transfer), 32'h1);
    chk("wait_cmd", 32'(m_cmd), 32'(cmd));
  endtask

  // nw WAIT cycles with stray read data, then complete with m_done.
  task automatic finish_txn(input int nw, input logic [DW-1:0] rd,
                            input logic [NREQ-1:0] m,
                            input logic [DW-1:0] ed);
    for (int i = 0; i < nw; i++) begin
      m_read_vld  = 1'b1;
      m_read_data = 8'hEE;
      tick();
    end
    m_read_vld  = 1'b1;
    m_read_data = rd;
    m_done      = 1'b1;
    push(m, ed, 1'b0);
    tick();
    m_done      = 1'b0;
    m_read_vld  = 1'b0;
    chk("done_grant", 32'(grant), 32'h0);
    chk("done_xfer", 32'(m_transfer), 32'h0);
    chk("done_busy", 32'(busy), 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_rdy"}, 32'(req_rdy), 32'h0);
    chk({tag, "_rsp"}, {15'h0, rsp_err, rsp_data, rsp_vld}, 32'h0);
    chk({tag, "_mcmd"}, 32'(m_cmd), 32'h0);
    chk({tag, "_mctl"}, {29'h0, m_cmd_vld, m_transfer, busy}, 32'h0);
  endtask

  initial begin
    logic [CMW-1:0] c;
    rstn        = 1'b0;
    req_cmd     = '0;
    req_vld     = '0;
    m_cmd_rdy   = 1'b0;
    m_done      = 1'b0;
    m_read_vld  = 1'b0;
    m_read_data = '0;
    req_vld     = 4'hF;
    #12;
    chk_zero("reset");
    req_vld = '0;
    tick();
    rstn = 1'b1;
    tick();

    // Stray m_done in IDLE is ignored (scoreboard flags any response).
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("idle_done_busy", 32'(busy), 32'h0);

    // Fairness: all requesting, each re-requests on its own rsp_vld cycle.
    for (int i = 0; i < NREQ; i++) begin
      c = {1'b1, 8'(i), 8'(i)};
      req_cmd[i*CMW +: CMW] = c;
    end
    req_vld = 4'hF;
    for (int t = 0; t < 5; t++) begin
      int w;
      w = t % NREQ;
      #1;
      chk("fair_rdy", 32'(req_rdy), 32'(NREQ'(1) << w));
      tick();
      chk("fair_grant", 32'(grant), 32'(NREQ'(1) << w));
      chk("fair_cmd", 32'(m_cmd), {15'h0, 1'b1, 8'(w), 8'(w)});
      m_cmd_rdy = 1'b1;
      tick();
      m_cmd_rdy = 1'b0;
      m_done    = 1'b1;
      push(NREQ'(1) << w, 8'h00, 1'b0);
      tick();
      m_done = 1'b0;
    end
    req_vld = '0;
    tick();

    // Single write from requester 0.
    start_txn(0, 17'h112A5);
    finish_txn(1, 8'h33, 4'b0001, 8'h00);

    // Read from requester 2; stray read data in the first WAIT cycle.
    start_txn(2, 17'h03400);
    finish_txn(1, 8'h5C, 4'b0100, 8'h5C);

    // Timeout on requester 3; requester 0 requests briefly and withdraws.
    start_txn(3, 17'h15678);
    for (int i = 0; i < 15; i++) begin
      if (i == 2) req_vld = 4'b0001;
      if (i == 5) req_vld = 4'b0000;
      tick();
    end
    chk("to_busy", 32'(busy), 32'h1);
    chk("to_rsp_early", 32'(rsp_vld), 32'h0);
    push(4'b1000, 8'h00, 1'b1);
    tick();
    chk("to_xfer", 32'(m_transfer), 32'h0);
    chk("to_busy_idle", 32'(busy), 32'h0);
    chk("to_grant", 32'(grant), 32'h0);

    // Next request accepted; withdrawn requester 0 is skipped.
    start_txn(1, 17'h0AB00);
    finish_txn(0, 8'h4D, 4'b0010, 8'h4D);

    // m_done on the timeout cycle completes normally.
    start_txn(2, 17'h09A00);
    for (int i = 0; i < 15; i++) tick();
    m_done      = 1'b1;
    m_read_vld  = 1'b1;
    m_read_data = 8'h77;
    push(4'b0100, 8'h77, 1'b0);
    tick();
    m_done     = 1'b0;
    m_read_vld = 1'b0;
    chk("col_grant", 32'(grant), 32'h0);

    // Reset mid-WAIT: outputs clear at once, no response, rr_ptr back to 0.
    start_txn(1, 17'h10102);
    tick();
    rstn = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_rsp", 32'(rsp_vld), 32'h0);
    req_vld = 4'b1010;
    #1;
    chk("post_rst_rdy", 32'(req_rdy), 32'h2);
    tick();
    req_vld   = '0;
    m_cmd_rdy = 1'b1;
    tick();
    m_cmd_rdy = 1'b0;
    m_done    = 1'b1;
    push(4'b0010, 8'h00, 1'b0);
    tick();
    m_done = 1'b0;
    tick();
    tick();
    chk("sb_empty", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
